// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared channel count, context encodings and the 1011 next-state function
package seq_det_pkg;
  localparam int NCH = 4;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    G1   = 3'd1,
    G10  = 3'd2,
    G101 = 3'd3,
    HIT  = 3'd4
  } state_e;
  function automatic state_e next_state(input state_e s, input logic b);
    case (s)
      IDLE:    next_state = b ? G1 : IDLE;
      G1:      next_state = b ? G1 : G10;
      G10:     next_state = b ? G101 : IDLE;
      G101:    next_state = b ? HIT : G10;
      HIT:     next_state = b ? G1 : G10;
      default: next_state = IDLE;
    endcase
  endfunction
endpackage

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: one-hot round-robin grant, search starting at ptr
module rr_arbiter_4 (
  input  logic [3:0] req_masked,
  input  logic [1:0] ptr,
  output logic [3:0] grant
);
  // scanning from the farthest offset down lets the nearest requester overwrite the rest
  always_comb begin
    grant = '0;
    for (int i = 3; i >= 0; i--)
      if (req_masked[ptr + 2'(i)]) begin
        grant = '0;
        grant[ptr + 2'(i)] = 1'b1;
      end
  end
endmodule

// File: rtl/seq_detect_arbiter.sv
// seq_detect_arbiter: four channels share one 1011 pattern engine through round-robin arbitration
module seq_detect_arbiter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       bit_in,
  input  logic [3:0]       clr,
  output logic [3:0]       grant,
  output logic             det_valid,
  output logic [1:0]       det_ch,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_out
);
  state_e           ctx_q [NCH];
  state_e           ctx_d [NCH];
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [1:0]       ptr_q, ptr_d, k, det_ch_q;
  logic             det_valid_q, hit;
  logic [3:0]       arb_grant;
  state_e           nxt;
  rr_arbiter_4 u_arb (
    .req_masked(req & ~clr),
    .ptr       (ptr_q),
    .grant     (arb_grant)
  );
  assign grant     = rst ? 4'b0 : arb_grant;
  assign k         = {arb_grant[3] | arb_grant[2], arb_grant[3] | arb_grant[1]};
  assign nxt       = next_state(ctx_q[k], bit_in[k]);
  assign hit       = |arb_grant && nxt == HIT;
  assign det_valid = det_valid_q;
  assign det_ch    = det_ch_q;
  assign cnt_out   = cnt_q[cnt_sel];
  // clr is applied last so it overrides any engine update on the same channel
  always_comb begin
    ctx_d = ctx_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    if (|arb_grant) begin
      ctx_d[k] = nxt;
      ptr_d    = k + 2'd1;
      if (hit && cnt_q[k] != '1) cnt_d[k] = cnt_q[k] + CNT_W'(1);
    end
    for (int i = 0; i < NCH; i++)
      if (clr[i]) begin
        ctx_d[i] = IDLE;
        cnt_d[i] = '0;
      end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        ctx_q[i] <= IDLE;
        cnt_q[i] <= '0;
      end
      ptr_q       <= '0;
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
    end else begin
      ctx_q       <= ctx_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      det_valid_q <= hit;
      det_ch_q    <= k;
    end
  end
endmodule

// File: doc/seq_detect_arbiter.md
SEQ_DETECT_ARBITER -- requirements
Module: seq_detect_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 8, which sets the width of each per-channel hit counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port req, input, 4 bits: per-channel request; the channel has a bit to be scanned.
REQ-005 SHALL have port bit_in, input, 4 bits: per-channel serial data bit, valid while req[i]=1.
REQ-006 SHALL have port clr, input, 4 bits: per-channel context clear, synchronous.
REQ-007 SHALL have port grant, output, 4 bits: one-hot combinational grant; the bit is consumed in the cycle where grant[i]=1.
REQ-008 SHALL have port det_valid, output, 1 bit: a registered detection strobe.
REQ-009 SHALL have port det_ch, output, 2 bits: the channel index qualified by det_valid.
REQ-010 SHALL have port cnt_sel, input, 2 bits: the counter read select.
REQ-011 SHALL have port cnt_out, output, CNT_W bits: the combinational read of hit_cnt[cnt_sel].

Function
REQ-012 SHALL share one 1011 pattern engine among 4 channels, granting at most one channel per cycle.
REQ-013 SHALL hold one 3-bit context per channel, with states IDLE, G1, G10, G101, HIT.
REQ-014 SHALL apply these transitions, written bit=0/bit=1:
- IDLE -> IDLE/G1
- G1 -> G10/G1
- G10 -> IDLE/G101
- G101 -> G10/HIT
- HIT -> G10/G1 (overlapping detection)
REQ-015 SHALL arbitrate round-robin: the search starts at ptr, and the first i with req[i]=1 and clr[i]=0 wins.
REQ-016 SHALL, on a grant to channel k, set ptr to (k+1) mod 4; ptr SHALL be unchanged when there is no grant.
REQ-017 SHALL, in a grant cycle, write the granted channel's context with next_state(ctx[k], bit_in[k]); contexts of ungranted channels SHALL hold.
REQ-018 SHALL assert det_valid=1 and det_ch=k in the cycle after a grant whose next state is HIT; det_valid SHALL be 0 otherwise.
REQ-019 SHALL increment hit_cnt[k] on each such detection and saturate it at 2^CNT_W-1.
REQ-020 SHALL keep grant at 0 when no req is eligible.
REQ-021 SHALL, when clr[i]=1, mask channel i from arbitration that cycle, set ctx[i] to IDLE and hit_cnt[i] to 0 at the edge, and discard the bit.
REQ-022 SHALL give clr precedence over a pending detection increment on the same channel; det_valid for that channel SHALL still fire if already registered.
REQ-023 SHALL leave requesters holding req and bit_in until granted; changing bit_in while ungranted SHALL have no effect on state.
REQ-024 SHALL let a channel that drops req without a grant lose nothing; its context persists across idle gaps.
REQ-025 SHALL produce a grant of exactly one hot bit or all zeros, never more than one.

Reset
REQ-026 SHALL, on rst=1, asynchronously set all contexts to IDLE, ptr to 0, det_valid to 0, det_ch to 0 and all hit_cnt to 0.
REQ-027 SHALL, when rst is asserted mid-stream, lose all partial matches; the first post-reset grant SHALL start from IDLE.
REQ-028 SHALL hold grant=0 while rst=1.

Structure
REQ-029 SHALL define the state encodings (IDLE=0, G1=1, G10=2, G101=3, HIT=4) and the channel count constant NCH=4 in the shared package seq_det_pkg.
REQ-030 SHALL implement arbitration as a sub-module rr_arbiter_4 with inputs req_masked and ptr and output grant one-hot.
REQ-031 SHALL keep the next-state function a pure combinational function in seq_det_pkg, reused by the single engine.

Verification
REQ-032 SHALL cover: a single channel 0 with req held and bits 1,0,1,1 -> det_valid=1, det_ch=0 one cycle after the 4th grant; hit_cnt[0]=1.
REQ-033 SHALL cover: overlap on channel 0 with bits 1,0,1,1,0,1,1 -> two detections after the 4th and 7th grants; cnt_out=2 with cnt_sel=0.
REQ-034 SHALL cover: req=4'b1111 continuously from reset -> grants 0001,0010,0100,1000,0001...; each channel advances once per 4 cycles.
REQ-035 SHALL cover: channels 1 and 3 interleaved, each fed 1011 -> detections det_ch=1 and det_ch=3 with no cross-contamination of contexts.
REQ-036 SHALL cover: clr[2]=1 while req[2]=1 after bits 1,0,1 -> no grant to ch2 that cycle, ctx[2]=IDLE, and a following 1 does not detect.
REQ-037 SHALL cover: hit_cnt at 255 (CNT_W=8) plus a further detection -> det_valid pulses and the count stays 255; rst mid-pattern -> all counters 0, ptr=0.
